// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the bounce generator: FSM states, LFSR polynomial, defaults.
package bounce_gen_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BOUNCE,
      SETTLE
   } state_t;

   localparam logic [15:0] LFSR_POLY = 16'hB400;

   localparam int unsigned DEF_MAX_BOUNCES   = 10;
   localparam int unsigned DEF_DELAY_W       = 4;
   localparam int unsigned DEF_SETTLE_CYCLES = 16;

   // One right-shift step of the Galois LFSR
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// Free-running 16-bit Galois LFSR; reloads the seed on reset.
module bounce_lfsr
   import bounce_gen_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   logic [15:0] r_value;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_value <= seed;
      else      r_value <= lfsr_next(r_value);
   end

   assign value = r_value;

endmodule

// File: rtl/bounce_generator.sv
// Emulates a bouncy push-button contact driven by a clean commanded level.
// Macro BOUNCE_GEN_RELEASE_BOUNCE_EN: when defined, releases (1->0) bounce too; otherwise they are clean.
module bounce_generator
   import bounce_gen_pkg::*;
#(
   parameter int unsigned MAX_BOUNCES   = DEF_MAX_BOUNCES,
   parameter int unsigned DELAY_W       = DEF_DELAY_W,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter logic [15:0] SEED          = 16'hACE1
)(
   input  logic clk,
   input  logic rst,
   input  logic level_in,
   output logic bounce_out,
   output logic busy
);

   localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [3:0]         MAX_N     = 4'(MAX_BOUNCES);
   localparam logic [SET_W-1:0]   SET_LOAD  = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [DELAY_W-1:0] DWELL_ONE = DELAY_W'(1);

   logic [15:0]        w_lfsr;
   logic [DELAY_W-1:0] w_dwell_raw;
   logic [DELAY_W-1:0] w_dwell_load;
   logic [3:0]         w_n_clip;
   logic [3:0]         w_n_load;
   logic               w_unused_lfsr;

   state_t             r_state;
   logic               r_level;
   logic               r_target;
   logic [3:0]         r_n;
   logic [DELAY_W-1:0] r_dwell;
   logic [SET_W-1:0]   r_settle;
   logic               r_bounce;
   logic               r_busy;

   bounce_lfsr u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .seed  (SEED),
      .value (w_lfsr)
   );

   assign w_unused_lfsr = ^w_lfsr;
   assign w_dwell_raw   = w_lfsr[DELAY_W-1:0];
   assign w_dwell_load  = (w_dwell_raw == '0) ? DWELL_ONE : w_dwell_raw;
   assign w_n_clip      = (w_lfsr[3:0] > MAX_N) ? MAX_N : w_lfsr[3:0];

`ifdef BOUNCE_GEN_RELEASE_BOUNCE_EN
   assign w_n_load = w_n_clip;
`else
   assign w_n_load = r_level ? w_n_clip : 4'd0;
`endif

   // Input sample stage plus the transition FSM; r_level is the live target while bouncing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_level  <= 1'b0;
         r_target <= 1'b0;
         r_n      <= 4'd0;
         r_dwell  <= '0;
         r_settle <= '0;
         r_bounce <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_level <= level_in;
         case (r_state)
            IDLE: begin
               if (r_level != r_bounce) begin
                  r_state  <= BOUNCE;
                  r_busy   <= 1'b1;
                  r_target <= r_level;
                  r_n      <= w_n_load;
                  r_dwell  <= '0;
               end
            end
            BOUNCE: begin
               r_target <= r_level;
               if (r_dwell > DWELL_ONE) begin
                  r_dwell <= r_dwell - DWELL_ONE;
               end else if (r_dwell == DWELL_ONE) begin
                  r_dwell <= '0;
                  r_n     <= r_n - 4'd1;
               end else if (r_n == 4'd0) begin
                  r_bounce <= r_level;
                  r_state  <= SETTLE;
                  r_settle <= SET_LOAD;
               end else begin
                  r_bounce <= ~r_bounce;
                  r_dwell  <= w_dwell_load;
               end
            end
            SETTLE: begin
               r_bounce <= r_target;
               if (r_settle == '0) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_settle <= r_settle - SET_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bounce_out = r_bounce;
   assign busy       = r_busy;

endmodule

// File: tb/tb_bounce_generator.sv
// Random and directed stimulus checked edge-by-edge against an offline schedule model.
module tb_bounce_generator;

   localparam int NMAX   = 512;
   localparam int MAXB_A = 10;
   localparam int SET_A  = 16;
   localparam int MAXB_B = 0;
   localparam int SET_B  = 4;
   localparam int DW     = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic lvl_in = 1'b0;
   logic out_a, busy_a, out_b, busy_b;

   int checks = 0;
   int errors = 0;
   int tog_a, tog_b;

   logic        stim [NMAX];
   logic [15:0] lf   [NMAX];
   logic        eo   [2][NMAX];
   logic        eb   [2][NMAX];

   bounce_generator u_dut_a (
      .clk(clk), .rst(rst), .level_in(lvl_in), .bounce_out(out_a), .busy(busy_a)
   );

   bounce_generator #(.MAX_BOUNCES(MAXB_B), .SETTLE_CYCLES(SET_B)) u_dut_b (
      .clk(clk), .rst(rst), .level_in(lvl_in), .bounce_out(out_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] step(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic fill(input int w, input int from, input int to, input logic o, input logic b, input int n);
      for (int e = from; e <= to && e <= n; e++) begin
         eo[w][e] = o;
         eb[w][e] = b;
      end
   endtask

   // Expected output/busy after each edge; stim[e] is the level sampled at edge e,
   // lf[e] the LFSR value in force just before edge e+1.
   task automatic plan(input int w, input int maxb, input int settle, input int n);
      int   k;
      logic cur;
      k   = 1;
      cur = 1'b0;
      eo[w][0] = 1'b0;
      eb[w][0] = 1'b0;
      while (k <= n) begin
         if (stim[k-1] == cur) begin
            fill(w, k, k, cur, 1'b0, n);
            k++;
         end else begin
            int   rem;
            int   a;
            int   d;
            logic o;
            rem = int'(lf[k-1][3:0]);
            if (rem > maxb) rem = maxb;
`ifndef BOUNCE_GEN_RELEASE_BOUNCE_EN
            if (stim[k-1] == 1'b0) rem = 0;
`endif
            o = cur;
            fill(w, k, k, o, 1'b1, n);
            a = k + 1;
            while (rem > 0 && a <= n) begin
               o = ~o;
               d = int'(lf[a-1][DW-1:0]);
               if (d == 0) d = 1;
               fill(w, a, a + d, o, 1'b1, n);
               a = a + 1 + d;
               rem--;
            end
            if (a <= n) o = stim[a-1];
            fill(w, a, a + settle - 1, o, 1'b1, n);
            fill(w, a + settle, a + settle, o, 1'b0, n);
            cur = o;
            k   = a + settle + 1;
         end
      end
   endtask

   task automatic gen_press(input int n, input int p, input int r);
      stim[0] = 1'b0;
      for (int e = 1; e <= n; e++) stim[e] = (e >= p && e < r);
   endtask

   task automatic gen_random(input int n);
      logic v;
      int   e;
      v = 1'($urandom_range(0, 1));
      stim[0] = 1'b0;
      e = 1;
      while (e <= n) begin
         int h;
         h = int'($urandom_range(1, 70));
         for (int j = 0; j < h && e <= n; j++) begin
            stim[e] = v;
            e++;
         end
         v = ~v;
      end
   endtask

   function automatic int pick_p(input int from, input int minn);
      for (int j = from; j < NMAX - 1; j++)
         if (int'(lf[j][3:0]) >= minn) return j;
      return from;
   endfunction

   // Reset (checked asynchronously and while held), then n edges compared against the model
   task automatic run_phase(input string name, input int n);
      plan(0, MAXB_A, SET_A, n);
      plan(1, MAXB_B, SET_B, n);
      rst    = 1'b0;
      lvl_in = 1'b1;
      #1;
      check($sformatf("%s async_rst out_a", name), 32'(out_a), 32'(0));
      check($sformatf("%s async_rst busy_a", name), 32'(busy_a), 32'(0));
      check($sformatf("%s async_rst out_b", name), 32'(out_b), 32'(0));
      for (int i = 0; i < 10; i++) begin
         #10;
         check($sformatf("%s hold_rst out_a", name), 32'(out_a), 32'(0));
         check($sformatf("%s hold_rst busy_a", name), 32'(busy_a), 32'(0));
      end
      @(negedge clk);
      rst    = 1'b1;
      lvl_in = stim[1];
      tog_a  = 0;
      tog_b  = 0;
      for (int k = 1; k <= n; k++) begin
         logic pa, pb;
         pa = out_a;
         pb = out_b;
         @(posedge clk);
         #1;
         if (out_a != pa) tog_a++;
         if (out_b != pb) tog_b++;
         check($sformatf("%s e%0d out_a", name, k), 32'(out_a), 32'(eo[0][k]));
         check($sformatf("%s e%0d busy_a", name, k), 32'(busy_a), 32'(eb[0][k]));
         check($sformatf("%s e%0d out_b", name, k), 32'(out_b), 32'(eo[1][k]));
         check($sformatf("%s e%0d busy_b", name, k), 32'(busy_b), 32'(eb[1][k]));
         if (k < n) begin
            @(negedge clk);
            lvl_in = stim[k+1];
         end
      end
   endtask

   initial begin
      int p;
      lf[0] = 16'hACE1;
      for (int j = 1; j < NMAX; j++) lf[j] = step(lf[j-1]);

      p = pick_p(4, 8);
      gen_press(300, p, NMAX);
      run_phase("press1", 300);
      check("press1 toggles_a_le_11", 32'(tog_a <= MAXB_A + 1), 32'(1));
      check("press1 toggles_b_one", 32'(tog_b), 32'(1));
      check("press1 final_a", 32'(out_a), 32'(1));

      run_phase("press2", 300);

      gen_press(300, p, p + 3);
      run_phase("retarget", 300);
      check("retarget final_a", 32'(out_a), 32'(0));

      gen_press(450, p, p + 250);
      run_phase("release", 450);
      check("release final_a", 32'(out_a), 32'(0));

      gen_press(p + 3, p, NMAX);
      run_phase("abort", p + 3);
      check("abort busy_a_mid", 32'(busy_a), 32'(1));

      for (int r = 0; r < 6; r++) begin
         gen_random(450);
         run_phase($sformatf("rand%0d", r), 450);
      end

      rst = 1'b0;
      #1;
      check("final async_rst out_a", 32'(out_a), 32'(0));
      check("final async_rst busy_a", 32'(busy_a), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bounce_generator.md
BOUNCE_GENERATOR -- requirements
Module: bounce_generator

Interface
REQ-001 SHALL provide parameter MAX_BOUNCES, default 10, meaning the maximum number of spurious toggles per transition (range 0-15).
REQ-002 SHALL provide parameter DELAY_W, default 4, meaning the width of the per-toggle random dwell field.
REQ-003 SHALL provide parameter SETTLE_CYCLES, default 16, meaning the number of cycles the output is held stable after a transition completes (minimum 1).
REQ-004 SHALL provide parameter SEED, default 16'hACE1, meaning the LFSR reset value (must be nonzero).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-007 SHALL have port level_in, input, 1, the clean commanded button level.
REQ-008 SHALL have port bounce_out, output, 1, the emulated bouncy contact level, registered.
REQ-009 SHALL have port busy, output, 1, high while a transition is bouncing or settling, registered.

Function
REQ-010 SHALL contain a 16-bit Galois LFSR, polynomial 0xB400, advancing every cycle when out of reset.
REQ-011 SHALL implement an FSM with states IDLE, BOUNCE and SETTLE.
- IDLE -> BOUNCE when level_in != bounce_out.
- BOUNCE -> SETTLE when the remaining bounce count is 0 and the dwell expires.
- SETTLE -> IDLE after SETTLE_CYCLES cycles.
REQ-012 SHALL, on IDLE exit, latch target = level_in and load bounce count n = min(lfsr[3:0], MAX_BOUNCES).
REQ-013 SHALL, in BOUNCE with n > 0, toggle bounce_out, then load dwell = lfsr[DELAY_W-1:0] (0 treated as 1), count it down, and decrement n on expiry.
REQ-014 SHALL, when n == 0, drive bounce_out = target on the next edge and enter SETTLE; with n == 0 at entry, bounce_out equals target exactly 2 cycles after the level_in change is sampled.
REQ-015 SHALL keep bounce_out == target at all cycles of SETTLE and IDLE, regardless of how many toggles occurred.
REQ-016 SHALL, if level_in changes during BOUNCE, update target to the new level_in and continue the current bounce sequence without reloading n.
REQ-017 SHALL ignore level_in changes during SETTLE; a mismatch present on return to IDLE starts a new transition.
REQ-018 SHALL assert busy in BOUNCE and SETTLE and deassert it in IDLE.
REQ-019 SHALL bound toggles per transition to MAX_BOUNCES + 1.

Reset
REQ-020 SHALL, on rst low, immediately force bounce_out = 0, busy = 0, state = IDLE, target = 0, n = 0, dwell = 0, lfsr = SEED.
REQ-021 SHALL abort any in-progress sequence on reset; after release the block is in IDLE and responds to level_in on the first rising edge.

Configuration
REQ-022 SHALL honour macro BOUNCE_GEN_RELEASE_BOUNCE_EN.
- Defined: both 0->1 and 1->0 transitions bounce per REQ-012..REQ-016.
- Undefined: 1->0 transitions load n = 0, giving a clean release per REQ-014; 0->1 transitions are unchanged.

Structure
REQ-023 SHALL take from shared package bounce_gen_pkg:
- the FSM state enum;
- the LFSR polynomial constant;
- the default MAX_BOUNCES, DELAY_W and SETTLE_CYCLES values.
REQ-024 SHALL place the LFSR in sub-module bounce_lfsr (ports clk, rst, seed, value).

Verification
REQ-025 Reset: hold rst = 0 for 100 ns with level_in = 1 -> bounce_out = 0, busy = 0 throughout; after release, a transition starts on the first edge.
REQ-026 MAX_BOUNCES = 0: level_in 0->1 -> bounce_out = 1 two cycles later, busy high for 1 + SETTLE_CYCLES cycles, zero extra toggles.
REQ-027 Default parameters, 0->1, hold 1000 ns -> bounce_out toggles at most 11 times, ends at 1, stays 1; busy drops; sequence is identical across two runs with SEED = 16'hACE1.
REQ-028 Retarget: level_in 0->1, then back to 0 during BOUNCE -> bounce_out settles at 0, with no IDLE visit in between.
REQ-029 Reset mid-BOUNCE: assert rst -> bounce_out = 0 and busy = 0 asynchronously; LFSR restarts at SEED.
REQ-030 Macro undefined: 1->0 release -> exactly one toggle to 0, two cycles after the change; a press still bounces.
